// File: rtl/l2_mem_bridge.sv
// l2_mem_bridge: serialises 512-bit L2 fills/writebacks into 16 x 32-bit
// beats on a valid/ready memory bus and returns the assembled fill line.
//
// Ports:
//   clk, nrst                      clock, async active-low reset
//   read_L2_MEM / write_L2_MEM     fill / writeback request levels
//   index/tag/write_tag/write_data line request from L2
//   ready_MEM_L2                   one-cycle completion pulse
//   read_data_MEM_L2               last completed fill line
//   mem_valid/we/addr/wdata        beat request to memory
//   mem_ready/mem_rdata            beat accept / read data
//   rd_line_cnt, wr_line_cnt       line counters (L2_MEM_BRIDGE_PERF_CNT_EN only)
module l2_mem_bridge #(
    parameter int DATA_W = 32,
    parameter int LINE_W = 512
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              read_L2_MEM,
    input  logic              write_L2_MEM,
    input  logic [3:0]        index_L2_MEM,
    input  logic [21:0]       tag_L2_MEM,
    input  logic [21:0]       write_tag_L2_MEM,
    input  logic [LINE_W-1:0] write_data_L2_MEM,
    output logic              ready_MEM_L2,
    output logic [LINE_W-1:0] read_data_MEM_L2,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef L2_MEM_BRIDGE_PERF_CNT_EN
    ,
    output logic [15:0]       rd_line_cnt,
    output logic [15:0]       wr_line_cnt
`endif
);

    localparam int BEATS = LINE_W / DATA_W;
    localparam logic [3:0] LAST = 4'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t             state, state_nxt;
    logic [3:0]         beat;
    logic [25:0]        wr_addr;
    logic [25:0]        rd_addr;
    logic [LINE_W-1:0]  wbuf;
    logic [LINE_W-1:0]  fbuf;
    logic               rd_pend;
    logic               last_beat;

    assign last_beat = mem_ready && (beat == LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (write_L2_MEM)     state_nxt = WR;
                else if (read_L2_MEM) state_nxt = RD;
            end
            WR:   if (last_beat) state_nxt = rd_pend ? RD : DONE;
            RD:   if (last_beat) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_valid    = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        ready_MEM_L2 = 1'b0;
        unique case (state)
            WR: begin
                mem_valid = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {wr_addr, beat, 2'b00};
                mem_wdata = wbuf[int'(beat) * DATA_W +: DATA_W];
            end
            RD: begin
                mem_valid = 1'b1;
                mem_addr  = {rd_addr, beat, 2'b00};
            end
            DONE:    ready_MEM_L2 = 1'b1;
            default: ;
        endcase
    end

    // Beat counter wraps 15 -> 0, which also clears it between phases.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            beat             <= '0;
            wr_addr          <= '0;
            rd_addr          <= '0;
            wbuf             <= '0;
            fbuf             <= '0;
            rd_pend          <= 1'b0;
            read_data_MEM_L2 <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    beat <= '0;
                    if (write_L2_MEM || read_L2_MEM) begin
                        wr_addr <= {write_tag_L2_MEM, index_L2_MEM};
                        rd_addr <= {tag_L2_MEM, index_L2_MEM};
                        wbuf    <= write_data_L2_MEM;
                        rd_pend <= read_L2_MEM;
                    end
                end
                WR: if (mem_ready) beat <= beat + 4'd1;
                RD: begin
                    if (mem_ready) begin
                        fbuf[int'(beat) * DATA_W +: DATA_W] <= mem_rdata;
                        beat <= beat + 4'd1;
                        // Top word arrives last; publish the whole line now.
                        if (beat == LAST)
                            read_data_MEM_L2 <=
                                {mem_rdata, fbuf[LINE_W-DATA_W-1:0]};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef L2_MEM_BRIDGE_PERF_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_line_cnt <= '0;
            wr_line_cnt <= '0;
        end else begin
            if (state == RD && last_beat && rd_line_cnt != 16'hFFFF)
                rd_line_cnt <= rd_line_cnt + 16'd1;
            if (state == WR && last_beat && wr_line_cnt != 16'hFFFF)
                wr_line_cnt <= wr_line_cnt + 16'd1;
        end
    end
`endif

endmodule
